xunit_m: RTL and testbench

XUNIT_M -- requirements
Module: xunit_m

---
 rtl/xunit_m_pkg.sv | 23 ++
 rtl/xunit_m_krom.sv | 9 +
 rtl/xunit_m.sv | 59 +++++
 tb/tb_xunit_m.sv | 130 +++++++++++++
 4 files changed

// File: rtl/xunit_m_pkg.sv
// xunit_m_pkg: shared SHA-256 schedule helpers, round-constant table and state encoding
package xunit_m_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXPAND} state_t;
   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction
endpackage

// File: rtl/xunit_m_krom.sv
// xunit_m_krom: combinational round-constant lookup K[t]
module xunit_m_krom
   import xunit_m_pkg::*;
(
   input  logic [5:0]  i_addr,
   output logic [31:0] o_k
);
   assign o_k = K_TAB[i_addr];
endmodule

// File: rtl/xunit_m.sv
// xunit_m: SHA-256 message schedule expander emitting W[t] and K[t] one round per running cycle
module xunit_m
   import xunit_m_pkg::*;
#(
   parameter int DELAY_W = 32,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               running,
   input  logic               run,
   output logic               done,
   input  logic [DATA_W-1:0]  in0,
   output logic [DATA_W-1:0]  out0,
   output logic [DATA_W-1:0]  out1,
   input  logic [DELAY_W-1:0] delay0
);
   state_t               r_state, w_next;
   logic [5:0]           r_t;
   logic [DELAY_W-1:0]   r_cnt;
   logic [31:0]          r_win [16];
   logic [DATA_W-1:0]    r_out0, r_out1;
   logic                 w_round;
   logic [31:0]          w_sched, w_w, w_k;
   xunit_m_krom u_krom (.i_addr(r_t), .o_k(w_k));
   // r_win[15] is W[t-1], r_win[0] is W[t-16]
   always_comb begin
      w_round = running && (r_state == S_EXPAND || (r_state == S_WAIT && r_cnt == '0));
      w_sched = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];
      w_w     = (r_t < 6'd16) ? in0 : w_sched;
      w_next  = run ? S_WAIT : !w_round ? r_state : (r_t == 6'd63) ? S_IDLE : S_EXPAND;
   end
   always_ff @(posedge clk)
      if (!rst) r_state <= S_IDLE;
      else r_state <= w_next;
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_t    <= '0;
         r_cnt  <= '0;
         r_out0 <= '0;
         r_out1 <= '0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else if (run) begin
         r_t   <= '0;
         r_cnt <= delay0;
      end else if (running && r_state == S_WAIT && r_cnt != '0) begin
         r_cnt <= r_cnt - DELAY_W'(1);
      end else if (w_round) begin
         r_t    <= r_t + 6'd1;
         r_out0 <= w_w;
         r_out1 <= w_k;
         for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
         r_win[15] <= w_w;
      end
   end
   assign out0 = r_out0;
   assign out1 = r_out1;
   assign done = (r_state == S_IDLE);
endmodule

// File: tb/tb_xunit_m.sv
// tb_xunit_m: directed checks of the schedule expander against a bench-side SHA-256 schedule model
module tb_xunit_m;
   logic        clk = 0, rst, running, run, done;
   logic [31:0] in0, out0, out1, delay0;
   logic [31:0] blk [16];
   logic [31:0] exp_w [64];
   int          total = 0, bad = 0, cur_t = 0;
   typedef struct {int t; logic [31:0] w; logic [31:0] k; bit hw;} vec_t;
   vec_t vt [8];
   xunit_m dut (.clk(clk), .rst(rst), .running(running), .run(run), .done(done),
                .in0(in0), .out0(out0), .out1(out1), .delay0(delay0));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s t=%0d got=%h want=%h", nm, cur_t, act, want);
      end
   endtask
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction
   task automatic build_model();
      for (int t = 0; t < 64; t++)
         if (t < 16) exp_w[t] = blk[t];
         else exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ {10'b0, exp_w[t-2][31:10]})
                       + exp_w[t-7]
                       + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ {3'b0, exp_w[t-15][31:3]})
                       + exp_w[t-16];
   endtask
   // issue run, wait dly cycles, then drive rounds 0..stop-1; optional pause before round pt
   task automatic stream(input int dly, input int pt, input int pn, input int stop, input bit tabw,
                         input logic [31:0] prev);
      run = 1; delay0 = dly; tick(); run = 0; delay0 = $urandom;
      for (int i = 0; i < dly; i++) begin
         in0 = $urandom;
         chk("wait_done", 32'(done), 0);
         chk("wait_out0", out0, prev);
         tick();
      end
      for (int t = 0; t < stop; t++) begin
         cur_t = t;
         if (t == pt) begin
            running = 0;
            repeat (pn) begin
               in0 = $urandom;
               tick();
               chk("pause_out0", out0, exp_w[t-1]);
               chk("pause_done", 32'(done), 0);
            end
            running = 1;
         end
         in0 = (t < 16) ? blk[t] : $urandom;
         chk("busy_done", 32'(done), 0);
         tick();
         chk("w", out0, exp_w[t]);
         chk("round_done", 32'(done), 32'(t == 63));
         for (int j = 0; j < 8; j++)
            if (vt[j].t == t) begin
               chk("tab_k", out1, vt[j].k);
               if (tabw && vt[j].hw) chk("tab_w", out0, vt[j].w);
            end
      end
   endtask
   task automatic hold_check(input logic [31:0] w63);
      repeat (3) begin
         tick();
         chk("hold_out0", out0, w63);
         chk("hold_out1", out1, 32'hc67178f2);
         chk("hold_done", 32'(done), 1);
      end
   endtask
   task automatic load_abc();
      for (int i = 0; i < 16; i++) blk[i] = 0;
      blk[0] = 32'h61626380;
      blk[15] = 32'h00000018;
      build_model();
   endtask
   initial begin
      vt[0] = '{0,  32'h61626380, 32'h428a2f98, 1};
      vt[1] = '{1,  32'h00000000, 32'h71374491, 1};
      vt[2] = '{15, 32'h00000018, 32'hc19bf174, 1};
      vt[3] = '{16, 32'h61626380, 32'he49b69c1, 1};
      vt[4] = '{17, 32'h000f0000, 32'hefbe4786, 1};
      vt[5] = '{18, 32'h7da86405, 32'h0fc19dc6, 1};
      vt[6] = '{40, 32'h00000000, 32'ha2bfe8a1, 0};
      vt[7] = '{63, 32'h00000000, 32'hc67178f2, 0};
      rst = 0; run = 0; running = 1; in0 = 0; delay0 = 0;
      tick(); tick();
      chk("rst_out0", out0, 0);
      chk("rst_out1", out1, 0);
      chk("rst_done", 32'(done), 1);
      rst = 1; run = 1;
      rst = 0; tick(); run = 0;
      chk("rst_over_run", 32'(done), 1);
      rst = 1; tick(); tick();
      chk("idle_done", 32'(done), 1);
      chk("idle_out0", out0, 0);
      load_abc();
      stream(0, -1, 0, 64, 1, 32'h0);
      hold_check(exp_w[63]);
      stream(5, -1, 0, 64, 1, exp_w[63]);
      hold_check(exp_w[63]);
      stream(0, 20, 3, 64, 1, exp_w[63]);
      hold_check(exp_w[63]);
      stream(0, -1, 0, 30, 1, exp_w[63]);
      rst = 0; tick(); rst = 1;
      chk("midrst_out0", out0, 0);
      chk("midrst_out1", out1, 0);
      chk("midrst_done", 32'(done), 1);
      repeat (4) begin
         in0 = $urandom; tick();
         chk("postrst_out0", out0, 0);
         chk("postrst_done", 32'(done), 1);
      end
      stream(0, -1, 0, 40, 1, 32'h0);
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      build_model();
      stream(0, -1, 0, 64, 0, 32'h0);
      hold_check(exp_w[63]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
